led_mux_scan_param: RTL
=======================

// Module: led_mux_scan_param
// PURPOSE
//  Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 8-digit mux.
//  Scans DIGITS digits at a programmable rate, with per-digit blink and blank masks and a global PWM brightness level.
//  Display data is double-buffered and updated only at frame boundaries, so the display never tears.
//  Sits between the MMIO LED/sseg core registers and the board an/sseg pins.
// PARAMETERS
//  DIGITS     8      number of digits scanned; >= 2
//  SCAN_DIV   12500  clocks per digit slot (100 MHz -> 8 kHz slot, 1 kHz frame at 8 digits); >= 2
//  BLINK_DIV  256    frames per blink half-period (~2 Hz toggle at defaults); >= 1
//  BRIGHT_W   4      brightness width; 2^BRIGHT_W PWM levels
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous, active-high reset
//  seg_in      in   8*DIGITS   digit patterns, active-low; digit i = seg_in[8*i+7:8*i]
//  blink_mask  in   DIGITS     1 = digit blinks
//  blank_mask  in   DIGITS     1 = digit forced dark
//  brightness  in   BRIGHT_W   PWM level; all-ones = full on
//  disp_en     in   1          0 = all digits dark; scanning continues
//  an          out  DIGITS     digit enables, one-hot active-low
//  sseg        out  8          segment pattern, active-low
//  frame_tick  out  1          1-cycle pulse at every frame boundary (shadow load)
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous and active-high.
//  Reset values:
//   - presc=0, idx=0, pwm_cnt=0, blink_cnt=0, blink_phase=0
//   - shadow seg all 8'hFF, shadow masks 0, shadow brightness all-ones
//   - an all-ones, sseg=8'hFF, frame_tick=0
//   - Display is dark until the first frame boundary.
//  Prescaler:
//   - presc counts 0..SCAN_DIV-1 and wraps.
//   - slot_tick = (presc == SCAN_DIV-1).
//   - On slot_tick, idx advances; DIGITS-1 wraps to 0.
//  Frame boundary = slot_tick && idx == DIGITS-1. In that same edge:
//   - shadows load seg_in, blink_mask, blank_mask, brightness
//   - frame_tick is registered high for exactly one cycle
//   - blink_cnt increments; on reaching BLINK_DIV-1 it wraps to 0 and blink_phase toggles
//  Mid-frame input changes have no visible effect until the next boundary.
//  PWM: pwm_cnt is a free-running BRIGHT_W-bit counter, +1 per clock, wraps.
//  Digit on = disp_en && !blank_sh[idx] && (pwm_cnt <= bright_sh).
//   - brightness 0 -> lit 1 of every 2^BRIGHT_W clocks
//   - all-ones -> always lit
//  Outputs are registered, 1-cycle latency from idx/pwm_cnt:
//   - an   = digit on ? ~(1 << idx) : all-ones
//   - sseg = (!digit on || (blink_phase && blink_sh[idx])) ? 8'hFF : seg_sh[idx]
//  disp_en is sampled live, not shadowed; counters keep running while it is 0.
//  Reset asserted mid-frame: an and sseg go dark immediately (async); scanning restarts at idx 0.
//  Widths: presc = $clog2(SCAN_DIV); idx = $clog2(DIGITS); blink_cnt = $clog2(BLINK_DIV+1).
// STRUCTURE
//  led_mux_pkg:
//   - typedef logic [7:0] seg_t
//   - localparam seg_t SEG_OFF = 8'hFF
//   - function onehot_low(idx, n)
//  Sub-module led_scan_timer: presc, idx, slot_tick, frame-boundary pulse; parameters DIGITS and SCAN_DIV.
//  Top level holds the shadow registers, blink and PWM counters, and the output registers.
// TESTING (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, BRIGHT_W=2)
//  1. Reset, then release: an=4'b1111 and sseg=FF throughout frame 0; frame_tick pulses 16 clocks after release, then every 16 clocks.
//  2. seg_in={8'h03,8'h02,8'h01,8'h00}, brightness=3, disp_en=1: after the first frame_tick, an steps 1110,1101,1011,0111 for 4 clocks each, with sseg 00,01,02,03.
//  3. Change seg_in to all 8'h55 during idx=1: sseg keeps the old values until the next frame_tick, then shows 55 on all digits.
//  4. blink_mask=4'b0010: digit1 sseg=FF for 2 frames, then shows its pattern for 2 frames, repeating; digits 0/2/3 are never blanked.
//  5. brightness=0: an is low in 1 of every 4 clocks per slot; blank_mask=4'b0100: an[2] never low; disp_en=0: an=4'b1111 while frame_tick continues.
//  6. Assert reset while idx=2: an=4'b1111 and sseg=FF in the same cycle (before any clock edge); after release, behaviour matches test 1.

Source files
------------

// File: rtl/led_mux_pkg.sv
// Shared types and helpers for the parametrised multiplexed 7-segment driver.
package led_mux_pkg;

  typedef logic [7:0] seg_t;

  // Pattern with every segment (and the decimal point) dark; segments are active-low.
  localparam seg_t SEG_OFF = 8'hFF;

  // Widest digit count the one-hot helper can produce.
  localparam int unsigned MAX_DIGITS = 64;

  // Active-low one-hot digit enable: bit idx low, all other bits high.
  // An idx at or beyond n leaves every bit high (all digits dark).
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input int unsigned idx,
                                                       input int unsigned n);
    logic [MAX_DIGITS-1:0] mask;
    mask = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i == idx) && (i < n)) begin
        mask[i] = 1'b0;
      end else begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Digit-slot timer: divides clk down to slot ticks, walks the digit index and
// flags the last slot of each frame.
module led_scan_timer #(
  parameter int  DIGITS   = 8,
  parameter int  SCAN_DIV = 12500,
  localparam int IDX_W    = $clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx,
  output logic             frame_bnd
);

  localparam int                 PRESC_W    = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               slot_tick;

  assign slot_tick = (presc_q == PRESC_LAST);
  // The frame ends when the last digit's slot expires.
  assign frame_bnd = slot_tick && (idx_q == IDX_LAST);
  assign idx       = idx_q;

  // Prescaler wraps every SCAN_DIV clocks; the digit index steps on each wrap.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (slot_tick) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Timer state register; reset restarts the scan at digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/led_mux_scan_param.sv
// N-digit multiplexed 7-segment driver with frame-synchronous shadow
// registers, per-digit blink/blank, and PWM brightness.
module led_mux_scan_param
  import led_mux_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 12500,
  parameter int BLINK_DIV = 256,
  parameter int BRIGHT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  disp_en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int                 IDX_W      = $clog2(DIGITS);
  localparam int                 BLINK_W    = $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [IDX_W-1:0]    idx_s;
  logic                frame_bnd_s;
  logic                digit_on_s;
  seg_t                cur_seg_s;

  logic [8*DIGITS-1:0] seg_sh_q, seg_sh_d;
  logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
  logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [BRIGHT_W-1:0] bright_sh_q, bright_sh_d;
  // Set by the first shadow load; keeps the display dark until real data arrives.
  logic                shadow_vld_q, shadow_vld_d;
  logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg_t                sseg_q, sseg_d;
  logic                frame_tick_q, frame_tick_d;

  led_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx_s),
    .frame_bnd (frame_bnd_s)
  );

  assign cur_seg_s  = seg_sh_q[{idx_s, 3'b000} +: 8];
  // disp_en acts live; everything else comes from the frame-stable shadows.
  assign digit_on_s = disp_en && shadow_vld_q && !blank_sh_q[idx_s] &&
                      (pwm_cnt_q <= bright_sh_q);

  // Shadow load, blink divider and frame pulse, all keyed to the frame boundary.
  always_comb begin
    seg_sh_d      = seg_sh_q;
    blink_sh_d    = blink_sh_q;
    blank_sh_d    = blank_sh_q;
    bright_sh_d   = bright_sh_q;
    shadow_vld_d  = shadow_vld_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_tick_d  = 1'b0;
    pwm_cnt_d     = pwm_cnt_q + BRIGHT_W'(1);
    if (frame_bnd_s) begin
      seg_sh_d     = seg_in;
      blink_sh_d   = blink_mask;
      blank_sh_d   = blank_mask;
      bright_sh_d  = brightness;
      shadow_vld_d = 1'b1;
      frame_tick_d = 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      frame_tick_d = 1'b0;
    end
  end

  // Next digit enable and segment pattern for the current slot.
  always_comb begin
    an_d   = '1;
    sseg_d = SEG_OFF;
    if (digit_on_s) begin
      an_d = DIGITS'(onehot_low(32'(idx_s), 32'(DIGITS)));
      if (blink_phase_q && blink_sh_q[idx_s]) begin
        sseg_d = SEG_OFF;
      end else begin
        sseg_d = cur_seg_s;
      end
    end else begin
      an_d   = '1;
      sseg_d = SEG_OFF;
    end
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_sh_q      <= {DIGITS{SEG_OFF}};
      blink_sh_q    <= '0;
      blank_sh_q    <= '0;
      bright_sh_q   <= '1;
      shadow_vld_q  <= 1'b0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      sseg_q        <= SEG_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      seg_sh_q      <= seg_sh_d;
      blink_sh_q    <= blink_sh_d;
      blank_sh_q    <= blank_sh_d;
      bright_sh_q   <= bright_sh_d;
      shadow_vld_q  <= shadow_vld_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule
